// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-port register file
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    typedef struct packed {
        logic                en;
        reg_addr_t           addr;
        logic [XLEN_DEF-1:0] data;
    } wr_port_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, reserve and write-back observation signals of the register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    localparam int AW    = $clog2(NREGS)
);
    logic [NREAD-1:0][AW-1:0]    rs_addr;
    logic [NREAD-1:0][XLEN-1:0]  rs_data;
    logic [NREAD-1:0]            rs_busy;
    logic [NWRITE-1:0]           wr_en;
    logic [NWRITE-1:0][AW-1:0]   wr_addr;
    logic [NWRITE-1:0][XLEN-1:0] wr_data;
    logic                        rsv_en;
    logic [AW-1:0]               rsv_addr;
    logic [NWRITE-1:0]           wb_valid;
    logic [NWRITE-1:0][AW-1:0]   wb_addr;
    logic [NWRITE-1:0][XLEN-1:0] wb_data;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rs_data, rs_busy, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rs_data, rs_busy, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits, set by reservation and cleared by writes
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic [NREGS-1:0]         wr_hit,
    input  logic [NREAD-1:0][AW-1:0] rs_addr,
    output logic [NREAD-1:0]         busy
);
    logic [NREGS-1:0] bits;

    // a reservation outranks a same-edge write (newer producer); x0 never pends
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bits <= '0;
        else
            for (int i = 0; i < NREGS; i++)
                bits[i] <= (i != ZERO_REG) && ((rsv_en && rsv_addr == AW'(i)) || (bits[i] && !wr_hit[i]));
    end

    // raw busy lookup per read port; bypass masking happens in the top level
    always_comb begin
        for (int k = 0; k < NREAD; k++)
            busy[k] = bits[rs_addr[k]];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with bypass, scoreboard and write-back observation
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    logic [XLEN-1:0]           regs [NREGS];
    logic [NWRITE-1:0]         we;
    logic [NREGS-1:0]          wr_hit;
    logic [NREAD-1:0]          sb_busy;
    logic [NWRITE-1:0]         wb_valid;
    logic [NWRITE-1:0][AW-1:0] wb_addr;

    // effective writes: x0 is dropped and port 0 loses to port 1 on the same address
    always_comb begin
        for (int p = 0; p < NWRITE; p++)
            we[p] = bus.wr_en[p] && bus.wr_addr[p] != AW'(ZERO_REG);
        if (NWRITE == 2 && bus.wr_en[NWRITE-1] && bus.wr_addr[NWRITE-1] == bus.wr_addr[0])
            we[0] = 1'b0;
    end

    // one-hot map of registers receiving an effective write this edge
    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NWRITE; p++)
            if (we[p])
                wr_hit[bus.wr_addr[p]] = 1'b1;
    end

    // storage array; resolved enables never collide so port order is irrelevant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        else
            for (int p = 0; p < NWRITE; p++)
                if (we[p])
                    regs[bus.wr_addr[p]] <= bus.wr_data[p];
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .wr_hit   (wr_hit),
        .rs_addr  (bus.rs_addr),
        .busy     (sb_busy)
    );

    // read ports: stored value, optionally overridden by the winning same-cycle write
    always_comb begin
        logic [XLEN-1:0] rd;
        logic            hit;
        for (int k = 0; k < NREAD; k++) begin
            rd  = regs[bus.rs_addr[k]];
            hit = 1'b0;
            for (int p = 0; p < NWRITE; p++)
                if (BYPASS != 0 && we[p] && bus.wr_addr[p] == bus.rs_addr[k]) begin
                    rd  = bus.wr_data[p];
                    hit = 1'b1;
                end
            bus.rs_data[k] = rst ? '0 : rd;
            bus.rs_busy[k] = !rst && sb_busy[k] && !hit && bus.rs_addr[k] != AW'(ZERO_REG);
        end
    end

    // observation registers capture which writes committed on this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= '0;
            wb_addr  <= '0;
        end else begin
            wb_valid <= we;
            for (int p = 0; p < NWRITE; p++)
                wb_addr[p] <= we[p] ? bus.wr_addr[p] : '0;
        end
    end

    // committed value is read back from the array rather than copied from the input
    always_comb begin
        for (int p = 0; p < NWRITE; p++)
            bus.wb_data[p] = wb_valid[p] ? regs[wb_addr[p]] : '0;
    end

    assign bus.wb_valid = wb_valid;
    assign bus.wb_addr  = wb_addr;
endmodule
